// File: rtl/alarm_ringer_pkg.sv
// rtl/alarm_ringer_pkg.sv - shared state encoding, default parameters and width helpers
package alarm_ringer_pkg;

  typedef enum logic [1:0] {
    RINGER_IDLE   = 2'd0,
    RINGER_BUZZ   = 2'd1,
    RINGER_SNOOZE = 2'd2
  } ringer_state_e;

  localparam int DEF_TONE_DIV    = 50000;
  localparam int DEF_SNOOZE_SEC  = 300;
  localparam int DEF_TIMEOUT_SEC = 60;
  localparam int DEF_MAX_SNOOZE  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..maxval; never narrower than one bit.
  function automatic int cnt_width(input int maxval);
    return (maxval > 0) ? $clog2(maxval + 1) : 1;
  endfunction

endpackage

// File: rtl/alarm_ringer_tone_gen.sv
// rtl/alarm_ringer_tone_gen.sv - buzzer square-wave divider, restarts from zero on enable
module tone_gen
  import alarm_ringer_pkg::*;
#(
  parameter int TONE_DIV = DEF_TONE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tone_o
);

  localparam int CW = $clog2(TONE_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;

  // Held cleared while disabled, so every enable rise starts a fresh half-period.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!en_i) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == CW'(TONE_DIV - 1)) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm consumer: buzzer envelope, stop/snooze handling, end_ring pulse
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int TONE_DIV    = DEF_TONE_DIV,
  parameter int SNOOZE_SEC  = DEF_SNOOZE_SEC,
  parameter int TIMEOUT_SEC = DEF_TIMEOUT_SEC,
  parameter int MAX_SNOOZE  = DEF_MAX_SNOOZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick_1hz,
  input  logic                              ring,
  input  logic                              btn_stop,
  input  logic                              btn_snooze,
  output logic                              end_ring,
  output logic                              buzzer,
  output logic                              active,
  output logic                              snoozing,
  output logic [cnt_width(MAX_SNOOZE)-1:0]  snooze_used
);

  localparam int SEC_MAX = max_int(SNOOZE_SEC, TIMEOUT_SEC);
  localparam int SEC_W   = cnt_width(SEC_MAX);
  localparam int SU_W    = cnt_width(MAX_SNOOZE);

  ringer_state_e    state_q, state_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [SU_W-1:0]  used_q, used_d;
  logic             env_q, env_d;
  logic             from_ring_q, from_ring_d;
  logic             end_ring_q, end_ring_d;
  logic             stop_prev_q, snz_prev_q, ring_prev_q;

  logic             stop_edge, snz_edge, ring_rise;
  logic             timeout_hit, snooze_done, can_snooze;
  logic [SEC_W-1:0] sec_inc;
  logic             tone;

  assign stop_edge   = btn_stop & ~stop_prev_q;
  assign snz_edge    = btn_snooze & ~snz_prev_q;
  assign ring_rise   = ring & ~ring_prev_q;
  assign sec_inc     = (sec_cnt_q == SEC_W'(SEC_MAX)) ? sec_cnt_q : sec_cnt_q + 1'b1;
  assign timeout_hit = tick_1hz && (sec_cnt_q == SEC_W'(TIMEOUT_SEC - 1));
  assign snooze_done = tick_1hz && (sec_cnt_q == SEC_W'(SNOOZE_SEC - 1));
  assign can_snooze  = used_q < SU_W'(MAX_SNOOZE);

  always_comb begin
    state_d     = state_q;
    sec_cnt_d   = sec_cnt_q;
    used_d      = used_q;
    env_d       = env_q;
    from_ring_d = from_ring_q;
    end_ring_d  = 1'b0;
    case (state_q)
      RINGER_IDLE: begin
        if (ring) begin
          state_d     = RINGER_BUZZ;
          from_ring_d = 1'b1;
          used_d      = '0;
          sec_cnt_d   = '0;
          env_d       = 1'b1;
        end
      end
      RINGER_BUZZ: begin
        // Buttons outrank the tick; a spent snooze budget degrades to stop.
        if (stop_edge || ((snz_edge || timeout_hit) && !can_snooze)) begin
          state_d    = RINGER_IDLE;
          end_ring_d = from_ring_q;
          sec_cnt_d  = '0;
          env_d      = 1'b0;
        end else if (snz_edge || timeout_hit) begin
          state_d    = RINGER_SNOOZE;
          end_ring_d = from_ring_q;
          used_d     = used_q + 1'b1;
          sec_cnt_d  = '0;
        end else if (from_ring_q && !ring) begin
          state_d   = RINGER_IDLE;
          sec_cnt_d = '0;
          env_d     = 1'b0;
        end else if (tick_1hz) begin
          env_d     = ~env_q;
          sec_cnt_d = sec_inc;
        end
      end
      RINGER_SNOOZE: begin
        if (stop_edge) begin
          state_d   = RINGER_IDLE;
          sec_cnt_d = '0;
          env_d     = 1'b0;
        end else if (ring_rise || snooze_done) begin
          state_d     = RINGER_BUZZ;
          from_ring_d = ring_rise;
          sec_cnt_d   = '0;
          env_d       = 1'b1;
        end else if (tick_1hz) begin
          sec_cnt_d = sec_inc;
        end
      end
      default: begin
        state_d = RINGER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RINGER_IDLE;
      sec_cnt_q   <= '0;
      used_q      <= '0;
      env_q       <= 1'b0;
      from_ring_q <= 1'b0;
      end_ring_q  <= 1'b0;
      stop_prev_q <= 1'b0;
      snz_prev_q  <= 1'b0;
      ring_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_cnt_q   <= sec_cnt_d;
      used_q      <= used_d;
      env_q       <= env_d;
      from_ring_q <= from_ring_d;
      end_ring_q  <= end_ring_d;
      stop_prev_q <= btn_stop;
      snz_prev_q  <= btn_snooze;
      ring_prev_q <= ring;
    end
  end

  tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == RINGER_BUZZ),
    .tone_o(tone)
  );

  assign buzzer      = (state_q == RINGER_BUZZ) & tone & env_q;
  assign end_ring    = end_ring_q;
  assign active      = (state_q != RINGER_IDLE);
  assign snoozing    = (state_q == RINGER_SNOOZE);
  assign snooze_used = used_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - scoreboard bench for alarm_ringer with directed scenarios
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       ring = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       end_ring, buzzer, active, snoozing;
  logic [1:0] snooze_used;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } probe_t;

  logic [4:0] ev_q[$];
  probe_t     pr_q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  bit         end_req = 1'b0;
  logic [4:0] last_obs = 5'd0;
  logic [4:0] mon_o5;
  logic [5:0] mon_o6;
  logic [4:0] mon_exp;
  probe_t     mon_p;
  int         c0, c1;

  alarm_ringer #(
    .TONE_DIV   (4),
    .SNOOZE_SEC (3),
    .TIMEOUT_SEC(5),
    .MAX_SNOOZE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .ring       (ring),
    .btn_stop   (btn_stop),
    .btn_snooze (btn_snooze),
    .end_ring   (end_ring),
    .buzzer     (buzzer),
    .active     (active),
    .snoozing   (snoozing),
    .snooze_used(snooze_used)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event layout {end_ring, active, snoozing, snooze_used}; probes prepend buzzer.
  function automatic logic [4:0] ev(bit er, bit act, bit snz, logic [1:0] u);
    return {er, act, snz, u};
  endfunction

  function automatic logic [5:0] pv(bit bz, bit er, bit act, bit snz, logic [1:0] u);
    return {bz, er, act, snz, u};
  endfunction

  task automatic push_ev(input logic [4:0] v);
    ev_q.push_back(v);
  endtask

  task automatic push_pr(input int at, input logic [5:0] v);
    probe_t p;
    p.cyc = at;
    p.val = v;
    pr_q.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      step(gap);
      pulse_tick();
    end
  endtask

  task automatic press_stop();
    btn_stop = 1'b1;
    step(1);
    btn_stop = 1'b0;
  endtask

  task automatic press_snooze();
    btn_snooze = 1'b1;
    step(1);
    btn_snooze = 1'b0;
  endtask

  always @(negedge clk) begin
    mon_o5 = {end_ring, active, snoozing, snooze_used};
    mon_o6 = {buzzer, mon_o5};
    if (mon_en) begin
      if (mon_o5 != last_obs) begin
        total++;
        if (ev_q.size() == 0) begin
          bad++;
          $display("FAIL event_unexpected: got %b want none at cyc %0d", mon_o5, cyc);
        end else begin
          mon_exp = ev_q.pop_front();
          if (mon_exp != mon_o5) begin
            bad++;
            $display("FAIL event: got %b want %b at cyc %0d", mon_o5, mon_exp, cyc);
          end
        end
      end
      last_obs = mon_o5;
      while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
        mon_p = pr_q.pop_front();
        total++;
        if (mon_p.cyc != cyc || mon_p.val != mon_o6) begin
          bad++;
          $display("FAIL probe@%0d: got %b want %b (now cyc %0d)", mon_p.cyc, mon_o6, mon_p.val, cyc);
        end
      end
    end
    if (end_req) begin
      total++;
      if (ev_q.size() != 0) begin
        bad++;
        $display("FAIL events_pending: got %0d left want 0", ev_q.size());
      end
      total++;
      if (pr_q.size() != 0) begin
        bad++;
        $display("FAIL probes_pending: got %0d left want 0", pr_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    push_pr(cyc, pv(0, 0, 0, 0, 0));
    push_pr(cyc + 1, pv(0, 0, 0, 0, 0));
    step(2);

    // Basic ring, envelope, stop
    ring = 1'b1;
    c0 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(1, 0, 0, 0)); push_ev(ev(0, 0, 0, 0));
    push_pr(c0,      pv(0, 0, 0, 0, 0));
    push_pr(c0 + 1,  pv(0, 0, 1, 0, 0));
    push_pr(c0 + 4,  pv(0, 0, 1, 0, 0));
    push_pr(c0 + 5,  pv(1, 0, 1, 0, 0));
    push_pr(c0 + 7,  pv(0, 0, 1, 0, 0));
    push_pr(c0 + 10, pv(0, 0, 1, 0, 0));
    push_pr(c0 + 14, pv(1, 0, 1, 0, 0));
    push_pr(c0 + 16, pv(0, 1, 0, 0, 0));
    push_pr(c0 + 17, pv(0, 0, 0, 0, 0));
    step(6); pulse_tick(); step(5); pulse_tick(); step(2);
    press_stop(); ring = 1'b0;
    step(3);

    // Snooze then re-ring on expiry without end_ring
    ring = 1'b1;
    c0 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(1, 1, 1, 1)); push_ev(ev(0, 1, 1, 1));
    push_ev(ev(0, 1, 0, 1)); push_ev(ev(0, 0, 0, 1));
    push_pr(c0 + 4,  pv(0, 1, 1, 1, 1));
    push_pr(c0 + 5,  pv(0, 0, 1, 1, 1));
    push_pr(c0 + 12, pv(0, 0, 1, 1, 1));
    push_pr(c0 + 13, pv(0, 0, 1, 0, 1));
    push_pr(c0 + 16, pv(0, 0, 0, 0, 1));
    step(3); press_snooze(); ring = 1'b0;
    ticks(3, 2); step(2); press_stop();
    step(2);

    // Snooze limit
    ring = 1'b1;
    c0 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(1, 1, 1, 1)); push_ev(ev(0, 1, 1, 1));
    push_ev(ev(0, 1, 0, 1)); push_ev(ev(0, 1, 1, 2)); push_ev(ev(0, 1, 0, 2));
    push_ev(ev(0, 0, 0, 2));
    push_pr(c0 + 16, pv(0, 0, 1, 1, 2));
    push_pr(c0 + 28, pv(0, 0, 0, 0, 2));
    push_pr(c0 + 29, pv(0, 0, 0, 0, 2));
    step(3); press_snooze(); ring = 1'b0;
    ticks(3, 2); step(2); press_snooze();
    ticks(3, 2); step(2); press_snooze();
    step(3);

    // Auto-timeout
    ring = 1'b1;
    c0 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(1, 1, 1, 1)); push_ev(ev(0, 1, 1, 1));
    push_ev(ev(0, 1, 0, 1)); push_ev(ev(0, 0, 0, 1));
    push_pr(c0 + 12, pv(0, 0, 1, 0, 0));
    push_pr(c0 + 14, pv(1, 0, 1, 0, 0));
    push_pr(c0 + 15, pv(0, 1, 1, 1, 1));
    ticks(5, 2); ring = 1'b0;
    ticks(3, 2); press_stop();
    step(2);

    // Simultaneous stop+snooze, then tick+timeout+snooze
    ring = 1'b1;
    c0 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(1, 0, 0, 0)); push_ev(ev(0, 0, 0, 0));
    push_pr(c0 + 4, pv(0, 1, 0, 0, 0));
    push_pr(c0 + 5, pv(0, 0, 0, 0, 0));
    step(3);
    btn_stop = 1'b1; btn_snooze = 1'b1;
    step(1);
    btn_stop = 1'b0; btn_snooze = 1'b0; ring = 1'b0;
    step(2);
    ring = 1'b1;
    c1 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(1, 1, 1, 1)); push_ev(ev(0, 1, 1, 1));
    push_ev(ev(0, 0, 0, 1));
    push_pr(c1 + 15, pv(0, 1, 1, 1, 1));
    push_pr(c1 + 22, pv(0, 0, 1, 1, 1));
    push_pr(c1 + 23, pv(0, 0, 0, 0, 1));
    ticks(4, 2); step(2);
    tick_1hz = 1'b1; btn_snooze = 1'b1;
    step(1);
    tick_1hz = 1'b0; btn_snooze = 1'b0; ring = 1'b0;
    ticks(2, 2); step(1); press_stop();
    step(2);

    // External ring drop, async reset, held button across reset
    ring = 1'b1;
    c0 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(0, 0, 0, 0));
    push_pr(c0 + 4, pv(0, 0, 0, 0, 0));
    push_pr(c0 + 5, pv(0, 0, 0, 0, 0));
    step(3); ring = 1'b0; step(3);
    ring = 1'b1;
    c1 = cyc;
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(0, 0, 0, 0));
    push_ev(ev(0, 1, 0, 0)); push_ev(ev(0, 0, 0, 0));
    push_pr(c1 + 5,  pv(1, 0, 1, 0, 0));
    push_pr(c1 + 6,  pv(0, 0, 0, 0, 0));
    push_pr(c1 + 10, pv(0, 0, 0, 0, 0));
    push_pr(c1 + 13, pv(0, 0, 0, 0, 0));
    push_pr(c1 + 14, pv(0, 0, 1, 0, 0));
    push_pr(c1 + 18, pv(1, 0, 1, 0, 0));
    push_pr(c1 + 20, pv(0, 0, 0, 0, 0));
    step(6);
    rst = 1'b1; btn_stop = 1'b1; ring = 1'b0;
    step(3);
    rst = 1'b0;
    step(4);
    ring = 1'b1;
    step(6);
    btn_stop = 1'b0; ring = 1'b0;
    step(3);

    end_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL end_handshake: got no summary want summary");
    $fatal(1);
  end

endmodule
